regfile_access_ctrl: RTL
========================

Name: regfile_access_ctrl

Overview:
Initiator-side controller for the 8x4 register file write/read port (we/addr/wdata/rdata). It accepts single commands over a valid/ready request channel and drives the register file pins. Commands are write, read, read-modify-write increment, and whole-array fill. It returns one response per command over a valid/ready response channel, so upstream logic never toggles register-file pins directly.

Parameters:
DW, 4, data width of the register file and command/response data
AW, 3, address width; DEPTH = 2**AW entries (8)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  request valid
cmd_ready  out  1  controller can accept a request
cmd_op  in  2  opcode: 00 WRITE, 01 READ, 10 INC, 11 FILL
cmd_addr  in  AW  target address (ignored for FILL)
cmd_data  in  DW  write data / increment operand / fill value
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_op  out  2  opcode of the completed command
rsp_data  out  DW  result data
rf_we  out  1  register-file write enable
rf_addr  out  AW  register-file address
rf_wdata  out  DW  register-file write data
rf_rdata  in  DW  register-file read data; valid one cycle after rf_addr is presented
busy  out  1  command in progress (state != IDLE)

Behaviour:
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_op=0, rsp_data=0, rf_we=0, rf_addr=0, rf_wdata=0, busy=0.
- All outputs are registered except cmd_ready and busy, which are state decodes.
- rst takes priority over every other event, in any state.
- States: IDLE, WR, RD, CAP, WB, FILL, RESP.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready at an edge:
  - latch op, addr and data into internal registers; cmd_* may change afterwards;
  - go to WR (WRITE), RD (READ/INC) or FILL (FILL).
- WR: rf_we=1, rf_addr=addr, rf_wdata=data for exactly one cycle. Then RESP with rsp_data=data.
- RD: rf_we=0, rf_addr=addr. Then CAP.
- CAP: rf_rdata is sampled at the end of this cycle.
  - READ: rsp_data = sample, go to RESP.
  - INC: sum = (sample + data) mod 2**DW, carry discarded; go to WB.
- WB: rf_we=1, rf_addr=addr, rf_wdata=sum for one cycle. Then RESP with rsp_data=sum.
- FILL:
  - rf_we=1 for DEPTH consecutive cycles; rf_addr = 0,1,…,DEPTH-1 ascending; rf_wdata = data.
  - Internal counter wraps 7 -> 0 on the last write.
  - Then RESP with rsp_data=data.
- RESP: rsp_valid=1, rsp_op=op. rsp_valid, rsp_op and rsp_data are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready at an edge: rsp_valid=0 and go to IDLE.
  - If rsp_ready is already high when rsp_valid rises, rsp_valid lasts exactly one cycle.
- Latency, from the accept edge to rsp_valid high: WRITE 2 cycles, READ 3, INC 4, FILL DEPTH+1 (9).
- Minimum command-to-command spacing: one IDLE cycle after the response handshake. No accept occurs in RESP.
- rf_we is 0 in every state except WR, WB and FILL. rf_addr and rf_wdata hold their last values when rf_we=0.
- cmd_valid while busy: ignored (cmd_ready=0), no side effect.
- Reset mid-operation: the next cycle shows reset values, and the command is aborted with no response.
  - Writes whose rf_we cycle completed before the rst edge persist in the register file.
  - An aborted INC after CAP does not write back.

Test Plan:
- Bench uses a behavioural 8x4 register-file model attached to rf_* (read data valid one cycle after rf_addr).
1. rst 2 cycles, then WRITE addr=3 data=4'h5 -> rf_we high exactly 1 cycle with rf_addr=3, rf_wdata=5; rsp_valid at accept+2, rsp_data=5, rsp_op=00.
2. After scenario 1, READ addr=3 -> rf_we never high; rsp_valid at accept+3, rsp_data=4'h5.
3. INC addr=3 data=4'hC (stored 5) -> one rf_we with rf_wdata=4'h1 (wrap); rsp_data=1 at accept+4; READ addr=3 returns 1.
4. FILL data=4'hA -> rf_we high 8 consecutive cycles, rf_addr 0..7; rsp_valid at accept+9; READs of addr 0 and addr 7 return 4'hA.
5. Backpressure: rsp_ready=0 for 5 cycles during a READ response, with cmd_valid pulsed and cmd_data changed meanwhile -> rsp_valid and rsp_data stable, cmd_ready=0, busy=1, no extra rf_we; handshake then IDLE; only the original command takes effect.
6. FILL data=4'h7 over an array holding 4'hA, rst asserted in the cycle rf_addr=4 is driven -> next cycle all outputs at reset values, cmd_ready=1, no response; addrs 0..4 read 7, addrs 5..7 read 4'hA.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Single-command controller for an 8x4 register-file port: WRITE, READ, INC (read-modify-write), FILL.
// Latency accept->rsp_valid: WRITE 2, READ 3, INC 4, FILL DEPTH+1; response held until rsp_ready, no accept while busy.
module regfile_access_ctrl #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [1:0]    rsp_op,
    output logic [DW-1:0] rsp_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata,
    output logic          busy
);

    localparam logic [1:0]    OP_WRITE  = 2'b00;
    localparam logic [1:0]    OP_INC    = 2'b10;
    localparam logic [1:0]    OP_FILL   = 2'b11;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        WB,
        FILL,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] cnt_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] res_q;
    logic [DW-1:0] sum;
    logic          accept;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign sum       = rf_rdata + data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE: state_nxt = WR;
                        OP_FILL:  state_nxt = FILL;
                        default:  state_nxt = RD;
                    endcase
                end
            end
            WR:   state_nxt = RESP;
            RD:   state_nxt = CAP;
            CAP:  state_nxt = (op_q == OP_INC) ? WB : RESP;
            WB:   state_nxt = RESP;
            FILL: begin
                if (cnt_q == LAST_ADDR) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rf_* are loaded from the next state so the pins are live during WR/RD/WB/FILL;
    // rsp_valid rises one cycle after entering RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            res_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_op    <= '0;
            rsp_data  <= '0;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
        end else begin
            rf_we <= (state_nxt == WR) || (state_nxt == WB) || (state_nxt == FILL);
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= cmd_op;
                        addr_q <= cmd_addr;
                        data_q <= cmd_data;
                        res_q  <= cmd_data;
                        cnt_q  <= '0;
                        if (cmd_op == OP_FILL) begin
                            rf_addr  <= '0;
                            rf_wdata <= cmd_data;
                        end else begin
                            rf_addr <= cmd_addr;
                            if (cmd_op == OP_WRITE) begin
                                rf_wdata <= cmd_data;
                            end
                        end
                    end
                end
                CAP: begin
                    if (op_q == OP_INC) begin
                        res_q    <= sum;
                        rf_addr  <= addr_q;
                        rf_wdata <= sum;
                    end else begin
                        res_q <= rf_rdata;
                    end
                end
                FILL: begin
                    // counter wraps to zero on the last write, address holds at the top entry
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q != LAST_ADDR) begin
                        rf_addr <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_op    <= op_q;
                        rsp_data  <= res_q;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
